// File: rtl/vend_client.sv
// -----------------------------------------------------------------------------
// vend_client
//   Customer-side controller for a beverage dispenser. It collects coins into
//   a saturating credit balance. It validates a purchase against the price of
//   the chosen beverage. It strobes the dispenser and then waits for delivery
//   or a timeout. On a good delivery the returned change becomes the new
//   balance.
//
// Optional feature:
//   VEND_CLIENT_CHANGE_CHECK_EN - when defined, the returned change is checked
//   against (money - price). A mismatch still loads the change into the
//   balance, but it raises err/err_code=3 instead of done.
//
// Parameters:
//   PRICE1..PRICE3 - beverage prices in money units
//   REQ_HOLD       - cycles the selection strobe is held (1..15)
//   TIMEOUT        - WAIT cycles before the purchase is abandoned (1..255)
//
// Ports:
//   clk, rst                 - clock (rising edge), async active-high reset
//   coin_valid, coin_value   - one-cycle deposit strobe and amount
//   buy_req, buy_sel         - one-cycle purchase strobe and beverage (1..3)
//   money                    - credit presented to the dispenser
//   inbev1..3                - selection strobes to the dispenser
//   outbev1..3, change       - delivery indications and returned change
//   balance                  - current customer credit
//   busy, done, err          - purchase active / success pulse / failure pulse
//   err_code                 - 1 insufficient/invalid, 2 timeout, 3 wrong bev
//                              or bad change; holds until the next error
// -----------------------------------------------------------------------------
module vend_client #(
  parameter int PRICE1   = 150,
  parameter int PRICE2   = 175,
  parameter int PRICE3   = 200,
  parameter int REQ_HOLD = 2,
  parameter int TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [9:0] coin_value,
  input  logic       buy_req,
  input  logic [1:0] buy_sel,
  output logic [9:0] money,
  output logic       inbev1,
  output logic       inbev2,
  output logic       inbev3,
  input  logic       outbev1,
  input  logic       outbev2,
  input  logic       outbev3,
  input  logic [9:0] change,
  output logic [9:0] balance,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [9:0]  balance_reg, balance_next;
  logic [9:0]  money_reg, money_next;
  logic [1:0]  sel_reg, sel_next;
  logic [3:0]  hold_cnt_reg, hold_cnt_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic [9:0]  change_reg, change_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic [1:0]  err_code_reg, err_code_next;

  logic [10:0] coin_sum;
  logic [3:0]  outbev_vec;
  logic [3:0]  sel_onehot;
  logic        bev_match;
  logic        bev_wrong;
  logic [3:1]  inbev_vec;

  function automatic logic [9:0] price_of(input logic [1:0] s);
    case (s)
      2'd1:    price_of = 10'(PRICE1);
      2'd2:    price_of = 10'(PRICE2);
      2'd3:    price_of = 10'(PRICE3);
      default: price_of = 10'd0;
    endcase
  endfunction

  assign coin_sum   = {1'b0, balance_reg} + {1'b0, coin_value};

  // Bit 0 is a dummy slot, so sel_reg can index the vector directly.
  assign outbev_vec = {outbev3, outbev2, outbev1, 1'b0};
  assign sel_onehot = 4'b0001 << sel_reg;
  assign bev_match  = |(outbev_vec & sel_onehot);
  assign bev_wrong  = |(outbev_vec & ~sel_onehot);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      balance_reg  <= '0;
      money_reg    <= '0;
      sel_reg      <= '0;
      hold_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      change_reg   <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= '0;
    end else begin
      state_reg    <= state_next;
      balance_reg  <= balance_next;
      money_reg    <= money_next;
      sel_reg      <= sel_next;
      hold_cnt_reg <= hold_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      change_reg   <= change_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    balance_next  = balance_reg;
    money_next    = money_reg;
    sel_next      = sel_reg;
    hold_cnt_next = hold_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    change_next   = change_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    err_code_next = err_code_reg;

    case (state_reg)
      IDLE: begin
        money_next    = '0;
        hold_cnt_next = '0;
        wait_cnt_next = '0;
        if (coin_valid) begin
          balance_next = coin_sum[10] ? 10'h3FF : coin_sum[9:0];
        end
        // The buy is judged on the balance before this cycle's coin, but the
        // coin above is still credited.
        if (buy_req) begin
          if ((buy_sel != 2'd0) && (balance_reg >= price_of(buy_sel))) begin
            sel_next   = buy_sel;
            money_next = balance_reg;
            state_next = REQ;
          end else begin
            err_next      = 1'b1;
            err_code_next = 2'd1;
          end
        end
      end

      REQ: begin
        if (hold_cnt_reg == 4'(REQ_HOLD - 1)) begin
          hold_cnt_next = '0;
          state_next    = WAIT;
        end else begin
          hold_cnt_next = hold_cnt_reg + 4'd1;
        end
      end

      WAIT: begin
        // A delivery of the wrong beverage outranks a matching indication.
        if (bev_wrong) begin
          err_next      = 1'b1;
          err_code_next = 2'd3;
          money_next    = '0;
          state_next    = IDLE;
        end else if (bev_match) begin
          change_next = change;
          state_next  = DONE;
        end else if (wait_cnt_reg == 8'(TIMEOUT - 1)) begin
          err_next      = 1'b1;
          err_code_next = 2'd2;
          money_next    = '0;
          state_next    = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end

      DONE: begin
        balance_next = change_reg;
        money_next   = '0;
        state_next   = IDLE;
`ifdef VEND_CLIENT_CHANGE_CHECK_EN
        if (change_reg != (money_reg - price_of(sel_reg))) begin
          err_next      = 1'b1;
          err_code_next = 2'd3;
        end else begin
          done_next = 1'b1;
        end
`else
        done_next = 1'b1;
`endif
      end

      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 1; gi <= 3; gi++) begin : g_inbev
      assign inbev_vec[gi] = (state_reg == REQ) && (sel_reg == 2'(gi));
    end
  endgenerate

  assign inbev1   = inbev_vec[1];
  assign inbev2   = inbev_vec[2];
  assign inbev3   = inbev_vec[3];
  assign money    = (state_reg == IDLE) ? 10'd0 : money_reg;
  assign balance  = balance_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign err      = err_reg;
  assign err_code = err_code_reg;

endmodule

// File: tb/tb_vend_client.sv
// -----------------------------------------------------------------------------
// tb_vend_client
//   Directed test of vend_client with the default parameters
//   (prices 150/175/200, REQ_HOLD=2, TIMEOUT=16). Inputs change one time unit
//   after the rising edge. Outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_vend_client;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [9:0] coin_value;
  logic       buy_req;
  logic [1:0] buy_sel;
  logic [9:0] money;
  logic       inbev1, inbev2, inbev3;
  logic       outbev1, outbev2, outbev3;
  logic [9:0] change;
  logic [9:0] balance;
  logic       busy, done, err;
  logic [1:0] err_code;

  int check_cnt = 0;
  int pass_cnt  = 0;

  vend_client dut (
    .clk        (clk),
    .rst        (rst),
    .coin_valid (coin_valid),
    .coin_value (coin_value),
    .buy_req    (buy_req),
    .buy_sel    (buy_sel),
    .money      (money),
    .inbev1     (inbev1),
    .inbev2     (inbev2),
    .inbev3     (inbev3),
    .outbev1    (outbev1),
    .outbev2    (outbev2),
    .outbev3    (outbev3),
    .change     (change),
    .balance    (balance),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    check_cnt++;
    if (obs == exp) begin
      pass_cnt++;
      $display("check %-16s got %0d", tag, obs);
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic deposit(input int v);
    coin_valid = 1'b1;
    coin_value = 10'(v);
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic buy(input int s);
    buy_req = 1'b1;
    buy_sel = 2'(s);
    tick();
    buy_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // A run that stalls must still report itself as failed.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    coin_valid = 1'b0; coin_value = '0;
    buy_req = 1'b0; buy_sel = '0;
    outbev1 = 1'b0; outbev2 = 1'b0; outbev3 = 1'b0;
    change = '0;
    tick(); tick();
    check("rst_balance", balance, 0);
    check("rst_money", money, 0);
    check("rst_busy", busy, 0);
    check("rst_err_code", err_code, 0);
    check("rst_inbev", {inbev3, inbev2, inbev1}, 0);
    rst = 1'b0;

    // Normal purchase of beverage 1 with change 350.
    deposit(500);
    check("t1_balance", balance, 500);
    buy(1);
    check("t1_busy", busy, 1);
    check("t1_money", money, 500);
    check("t1_inbev1_c1", inbev1, 1);
    check("t1_inbev23", {inbev3, inbev2}, 0);
    tick();
    check("t1_inbev1_c2", inbev1, 1);
    tick();
    check("t1_inbev1_c3", inbev1, 0);
    check("t1_wait_busy", busy, 1);
    outbev1 = 1'b1; change = 10'd350;
    tick();
    outbev1 = 1'b0;
    check("t1_done_early", done, 0);
    tick();
    check("t1_done", done, 1);
    check("t1_balance_end", balance, 350);
    check("t1_money_end", money, 0);
    check("t1_busy_end", busy, 0);
    tick();
    check("t1_done_pulse", done, 0);

    // Insufficient balance for beverage 3.
    do_reset();
    deposit(100);
    buy(3);
    check("t2_err", err, 1);
    check("t2_err_code", err_code, 1);
    check("t2_inbev3", inbev3, 0);
    check("t2_busy", busy, 0);
    check("t2_balance", balance, 100);
    tick();
    check("t2_err_pulse", err, 0);
    check("t2_code_hold", err_code, 1);

    // Timeout on beverage 2, with a coin ignored during WAIT.
    deposit(400);
    check("t3_balance", balance, 500);
    buy(2);
    tick(); tick();
    repeat (5) tick();
    deposit(100);
    check("t3_coin_ignored", balance, 500);
    check("t3_busy_mid", busy, 1);
    repeat (9) tick();
    check("t3_err_early", err, 0);
    check("t3_busy_late", busy, 1);
    tick();
    check("t3_err", err, 1);
    check("t3_err_code", err_code, 2);
    check("t3_busy_end", busy, 0);
    check("t3_balance_end", balance, 500);

    // Invalid selection 0.
    buy(0);
    check("t4_err", err, 1);
    check("t4_err_code", err_code, 1);
    check("t4_balance", balance, 500);

    // Dispenser delivers the wrong beverage.
    buy(1);
    tick(); tick();
    outbev2 = 1'b1;
    tick();
    outbev2 = 1'b0;
    check("t5_err", err, 1);
    check("t5_err_code", err_code, 3);
    check("t5_balance", balance, 500);
    check("t5_busy", busy, 0);
    check("t5_money", money, 0);

    // Coin and buy in the same cycle: the buy uses the old balance.
    coin_valid = 1'b1; coin_value = 10'd100;
    buy_req = 1'b1; buy_sel = 2'd3;
    tick();
    coin_valid = 1'b0; buy_req = 1'b0;
    check("t6_busy", busy, 1);
    check("t6_money", money, 500);
    check("t6_balance", balance, 600);
    check("t6_inbev3", inbev3, 1);
    tick(); tick();
    outbev3 = 1'b1; change = 10'd300;
    tick();
    outbev3 = 1'b0;
    tick();
    check("t6_done", done, 1);
    check("t6_balance_end", balance, 300);

    // The balance saturates at 1023.
    do_reset();
    deposit(1000);
    check("t7_balance_1000", balance, 1000);
    deposit(100);
    check("t7_saturate", balance, 1023);
    deposit(1);
    check("t7_saturate2", balance, 1023);

    // Price boundary, coin+buy rejection, then reset in the middle of WAIT.
    do_reset();
    deposit(174);
    buy(2);
    check("t8_err_174", err, 1);
    coin_valid = 1'b1; coin_value = 10'd1;
    buy_req = 1'b1; buy_sel = 2'd2;
    tick();
    coin_valid = 1'b0; buy_req = 1'b0;
    check("t8_err_predep", err, 1);
    check("t8_busy_predep", busy, 0);
    check("t8_balance_175", balance, 175);
    buy(2);
    check("t8_busy_eq", busy, 1);
    check("t8_money_eq", money, 175);
    check("t8_inbev2_eq", inbev2, 1);
    tick(); tick();
    repeat (3) tick();
    check("t8_busy_wait", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t8_rst_busy", busy, 0);
    check("t8_rst_money", money, 0);
    check("t8_rst_balance", balance, 0);
    check("t8_rst_inbev", {inbev3, inbev2, inbev1}, 0);
    check("t8_rst_err_code", err_code, 0);
    check("t8_rst_flags", {done, err}, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t8_post_flags", {done, err}, 0);

    // Returned change of 300 where 500-150=350 was due.
    deposit(500);
    buy(1);
    tick(); tick();
    outbev1 = 1'b1; change = 10'd300;
    tick();
    outbev1 = 1'b0;
    tick();
`ifdef VEND_CLIENT_CHANGE_CHECK_EN
    check("t9_err", err, 1);
    check("t9_err_code", err_code, 3);
    check("t9_done", done, 0);
`else
    check("t9_done", done, 1);
    check("t9_err", err, 0);
`endif
    check("t9_balance", balance, 300);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
